// File: rtl/frame_config_writer.sv
// Configuration-column writer: turns (header, data) stream pairs into
// FrameData words and one-hot FrameStrobe pulses for one fabric column.
module frame_config_writer #(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int StrobeCycles    = 1,
  parameter logic [7:0] SyncByte = 8'hA5
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [FrameBitsPerRow-1:0] s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic [FrameBitsPerRow-1:0] FrameData,
  output logic [MaxFramesPerCol-1:0] FrameStrobe,
  output logic                       busy,
  output logic                       err_sync,
  output logic                       err_index,
  input  logic                       err_clr,
  output logic [15:0]                frame_count
);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    SETUP,
    STROBE,
    HOLD
  } state_t;

  localparam int CW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(StrobeCycles - 1);
  localparam logic [5:0] MAXF = 6'(MaxFramesPerCol);
  localparam logic [MaxFramesPerCol-1:0] ONE =
    {{(MaxFramesPerCol-1){1'b0}}, 1'b1};

  state_t        state;
  logic [4:0]    idx;
  logic          bad;
  logic [CW-1:0] cnt;
  logic [15:0]   fcount_q;
  logic          xfer;
  logic          sync_ok;
  logic          idx_bad;

  assign s_ready = (state == IDLE) || (state == DATA);
  assign busy    = (state == SETUP) || (state == STROBE) || (state == HOLD);
  assign xfer    = s_valid && s_ready;
  assign sync_ok = (s_data[31:24] == SyncByte);
  assign idx_bad = ({1'b0, s_data[4:0]} >= MAXF);
  assign frame_count = fcount_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      idx         <= '0;
      bad         <= 1'b0;
      cnt         <= '0;
      FrameData   <= '0;
      FrameStrobe <= '0;
      err_sync    <= 1'b0;
      err_index   <= 1'b0;
      fcount_q    <= '0;
    end else begin
      // clear first so that a same-cycle error set below takes priority
      if (err_clr) begin
        err_sync  <= 1'b0;
        err_index <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (xfer) begin
            if (!sync_ok) begin
              err_sync <= 1'b1;
            end else begin
              idx   <= s_data[4:0];
              bad   <= idx_bad;
              state <= DATA;
              if (idx_bad) err_index <= 1'b1;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            if (bad) begin
              state <= IDLE;
            end else begin
              FrameData <= s_data;
              state     <= SETUP;
            end
          end
        end
        SETUP: begin
          FrameStrobe <= ONE << idx;
          cnt         <= CNT_LOAD;
          state       <= STROBE;
        end
        STROBE: begin
          if (cnt == '0) begin
            FrameStrobe <= '0;
            fcount_q    <= fcount_q + 16'd1;
            state       <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          state <= IDLE;
        end
        default: begin
          FrameStrobe <= '0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_config_writer.sv
// Directed bench for frame_config_writer: timing, errors, reset,
// back-to-back strobes and frame_count wrap with random valid gaps.
module tb_frame_config_writer;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic [31:0] d1 = '0;
  logic        v1 = 1'b0;
  logic        c1 = 1'b0;
  logic        r1, b1, es1, ei1;
  logic [31:0] fd1;
  logic [19:0] fs1;
  logic [15:0] fc1;

  logic [31:0] d3 = '0;
  logic        v3 = 1'b0;
  logic        c3 = 1'b0;
  logic        r3, b3, es3, ei3;
  logic [31:0] fd3;
  logic [19:0] fs3;
  logic [15:0] fc3;

  frame_config_writer #(.StrobeCycles(1)) u1 (
    .CLK(CLK), .RST(RST), .s_data(d1), .s_valid(v1), .s_ready(r1),
    .FrameData(fd1), .FrameStrobe(fs1), .busy(b1), .err_sync(es1),
    .err_index(ei1), .err_clr(c1), .frame_count(fc1)
  );

  frame_config_writer #(.StrobeCycles(3)) u3 (
    .CLK(CLK), .RST(RST), .s_data(d3), .s_valid(v3), .s_ready(r3),
    .FrameData(fd3), .FrameStrobe(fs3), .busy(b3), .err_sync(es3),
    .err_index(ei3), .err_clr(c3), .frame_count(fc3)
  );

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  always @(posedge CLK) cyc++;

  logic [51:0] capq[$];
  logic [19:0] prev1 = '0;
  always @(negedge CLK) begin
    if (fs1 != 0 && prev1 == 0) capq.push_back({fd1, fs1});
    prev1 = fs1;
  end

  int run3 = 0;
  int multi3 = 0;
  int runs[$];
  int rises[$];
  logic [19:0] val3[$];
  logic [19:0] p3 = '0;
  always @(negedge CLK) begin
    if (!$onehot0(fs3)) multi3++;
    if (fs3 != 0) begin
      if (p3 == 0) begin
        rises.push_back(cyc);
        val3.push_back(fs3);
      end
      run3++;
    end else if (p3 != 0) begin
      runs.push_back(run3);
      run3 = 0;
    end
    p3 = fs3;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send1(input logic [31:0] w, input bit rnd);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    d1 = w;
    while (!done) begin
      v1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (v1 && r1) begin
        tick();
        v1 = 1'b0;
        done = 1'b1;
      end else begin
        tick();
        n++;
        if (n > 200) begin
          chk("send1_timeout", 64'd0, 64'd1);
          v1 = 1'b0;
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic send3(input logic [31:0] w);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    d3 = w;
    while (!done) begin
      if (r3) begin
        tick();
        done = 1'b1;
      end else begin
        tick();
        n++;
        if (n > 50) begin
          chk("send3_timeout", 64'd0, 64'd1);
          done = 1'b1;
        end
      end
    end
  endtask

  logic [51:0] expq[$];

  initial begin
    logic [31:0] w;
    #12;
    chk("rst_fd", 64'(fd1), 64'h0);
    chk("rst_fs", 64'(fs1), 64'h0);
    chk("rst_fc", 64'(fc1), 64'h0);
    chk("rst_err", 64'({es1, ei1}), 64'h0);
    RST = 1'b0;
    tick();
    chk("rst_ready", 64'(r1), 64'h1);

    send1(32'hA500_0003, 1'b0);
    send1(32'hDEAD_BEEF, 1'b0);
    chk("t1_fd_e0", 64'(fd1), 64'hDEAD_BEEF);
    chk("t1_fs_e0", 64'(fs1), 64'h0);
    chk("t1_rdy_e0", 64'({r1, b1}), 64'h1);
    tick();
    chk("t1_fs_e1", 64'(fs1), 64'h8);
    tick();
    chk("t1_fs_e2", 64'(fs1), 64'h0);
    chk("t1_fc", 64'(fc1), 64'h1);
    chk("t1_rdy_e2", 64'(r1), 64'h0);
    tick();
    chk("t1_rdy_e3", 64'({r1, b1}), 64'h2);

    send1(32'h5A00_0001, 1'b0);
    chk("t2_err_sync", 64'({es1, ei1}), 64'h2);
    chk("t2_ready", 64'(r1), 64'h1);
    send1(32'hA500_0002, 1'b0);
    send1(32'h1111_1111, 1'b0);
    tick();
    chk("t2_fs", 64'(fs1), 64'h4);
    tick();
    tick();
    chk("t2_fc", 64'(fc1), 64'h2);
    chk("t2_fd", 64'(fd1), 64'h1111_1111);
    c1 = 1'b1;
    tick();
    c1 = 1'b0;
    chk("t2_clr", 64'(es1), 64'h0);
    c1 = 1'b1;
    send1(32'h5A00_0000, 1'b0);
    c1 = 1'b0;
    chk("t2_set_wins", 64'(es1), 64'h1);
    c1 = 1'b1;
    tick();
    c1 = 1'b0;
    chk("t2_clr2", 64'(es1), 64'h0);

    send1(32'hA500_0014, 1'b0);
    chk("t3_err_index", 64'({es1, ei1}), 64'h1);
    chk("t3_data_ready", 64'(r1), 64'h1);
    send1(32'h1234_5678, 1'b0);
    chk("t3_idle_ready", 64'(r1), 64'h1);
    chk("t3_fd", 64'(fd1), 64'h1111_1111);
    tick();
    chk("t3_fs", 64'(fs1), 64'h0);
    chk("t3_fc", 64'(fc1), 64'h2);
    c1 = 1'b1;
    tick();
    c1 = 1'b0;
    chk("t3_clr", 64'(ei1), 64'h0);

    v3 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send3(32'hA500_0000);
      send3(32'h100 + 32'(i));
    end
    v3 = 1'b0;
    repeat (8) tick();
    chk("t4_nruns", 64'(runs.size()), 64'd8);
    chk("t4_nrises", 64'(rises.size()), 64'd8);
    for (int i = 0; i < 8 && i < runs.size(); i++)
      chk($sformatf("t4_run%0d", i), 64'(runs[i]), 64'd3);
    for (int i = 1; i < 8 && i < rises.size(); i++)
      chk($sformatf("t4_period%0d", i), 64'(rises[i] - rises[i-1]), 64'd7);
    for (int i = 0; i < 8 && i < val3.size(); i++)
      chk($sformatf("t4_val%0d", i), 64'(val3[i]), 64'h1);
    chk("t4_multihot", 64'(multi3), 64'd0);
    chk("t4_fc", 64'(fc3), 64'd8);
    chk("t4_fd", 64'(fd3), 64'h107);

    send1(32'hA500_0005, 1'b0);
    send1(32'hCAFE_F00D, 1'b0);
    tick();
    chk("t5_fs_pre", 64'(fs1), 64'h20);
    #1 RST = 1'b1;
    #1;
    chk("t5_fs_async", 64'(fs1), 64'h0);
    chk("t5_fd_async", 64'(fd1), 64'h0);
    chk("t5_fc_async", 64'(fc1), 64'h0);
    chk("t5_busy_async", 64'(b1), 64'h0);
    #1 RST = 1'b0;
    tick();
    chk("t5_ready", 64'(r1), 64'h1);
    send1(32'hA500_0001, 1'b0);
    send1(32'h0BAD_CAFE, 1'b0);
    tick();
    chk("t5_fs_after", 64'(fs1), 64'h2);
    chk("t5_fd_after", 64'(fd1), 64'h0BAD_CAFE);
    tick();
    tick();

    force u1.fcount_q = 16'hFFFF;
    tick();
    release u1.fcount_q;
    tick();
    chk("t6_preload", 64'(fc1), 64'hFFFF);
    capq.delete();
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      expq.push_back({w, 20'(20'h1 << (i + 10))});
      send1(32'hA500_0000 | 32'(i + 10), 1'b1);
      send1(w, 1'b1);
      if (i == 0) begin
        tick();
        tick();
        chk("t6_wrap", 64'(fc1), 64'h0);
      end
    end
    repeat (5) tick();
    chk("t6_fc_final", 64'(fc1), 64'd5);
    chk("t6_ncap", 64'(capq.size()), 64'd6);
    for (int i = 0; i < 6 && i < capq.size(); i++)
      chk($sformatf("t6_cap%0d", i), 64'(capq[i]), 64'(expq[i]));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
